// File: rtl/cpu_defs.sv
// Shared definitions for the execute-stage HI/LO unit: HI/LO source encodings,
// divider iteration count and the controller state type.
package cpu_defs;

    localparam logic [1:0] HILO_SRC_MUL  = 2'b00;
    localparam logic [1:0] HILO_SRC_DIV  = 2'b01;
    localparam logic [1:0] HILO_SRC_REG  = 2'b10;
    localparam logic [1:0] HILO_SRC_NONE = 2'b11;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/div_iter.sv
// Unsigned 32-bit radix-2 restoring divider. The first quotient bit is resolved
// on the start edge, so the result is ready while done is high (iteration 31).
module div_iter
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    logic        run_q, run_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [63:0] nxt;

    // One restoring step: shift the next dividend bit into the partial remainder.
    function automatic logic [63:0] step(input logic [31:0] r, input logic [31:0] q,
                                         input logic [31:0] d);
        logic [32:0] t;
        t = {r, q[31]};
        if (t >= {1'b0, d})
            return {t[31:0] - d, q[30:0], 1'b1};
        else
            return {t[31:0], q[30:0], 1'b0};
    endfunction

    assign done      = run_q && (cnt_q == 6'(DIV_ITERS - 1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        nxt   = '0;
        if (start) begin
            nxt   = step(32'd0, dividend, divisor);
            rem_d = nxt[63:32];
            quo_d = nxt[31:0];
            dvs_d = divisor;
            run_d = 1'b1;
            cnt_d = '0;
        end else if (run_q) begin
            if (done) begin
                run_d = 1'b0;
                cnt_d = '0;
            end else begin
                nxt   = step(rem_q, quo_q, dvs_q);
                rem_d = nxt[63:32];
                quo_d = nxt[31:0];
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
    end

endmodule

// File: rtl/mul_div_hilo.sv
// Execute-stage HI/LO unit: single-cycle multiply, 32-cycle divide, MTHI/MTLO,
// and the architectural HI/LO registers with a stall indication.
module mul_div_hilo
    import cpu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             op_valid,
    input  logic             mul,
    input  logic             div,
    input  logic             mul_signed,
    input  logic             div_signed,
    input  logic             HI_write,
    input  logic             LO_write,
    input  logic [1:0]       HI_MemtoReg,
    input  logic [1:0]       LO_MemtoReg,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               issue;
    logic               hiw_q, low_q, negq_q, negr_q;
    logic [1:0]         hi_src_q, lo_src_q;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] prod_q;
    logic signed [2*WIDTH-1:0] ma, mb, prod;
    logic [WIDTH-1:0]   abs_a, abs_b, dq, dr, q_fix, r_fix;
    logic               div_done;

    function automatic logic [WIDTH-1:0] hilo_sel(input logic [1:0] src,
            input logic [WIDTH-1:0] cur, input logic [WIDTH-1:0] m,
            input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] r);
        case (src)
            HILO_SRC_MUL: return m;
            HILO_SRC_DIV: return d;
            HILO_SRC_REG: return r;
            default:      return cur;
        endcase
    endfunction

    assign issue = op_valid && (state_q == IDLE) && (mul || div);
    assign busy  = (state_q != IDLE);
    assign hi    = hi_q;
    assign lo    = lo_q;

    // Extending straight to 64 bits gives the same low 64 product bits as 33-bit extension.
    assign ma   = mul_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
    assign mb   = mul_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
    assign prod = ma * mb;

    assign abs_a = (div_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign abs_b = (div_signed && src_b[WIDTH-1]) ? -src_b : src_b;
    assign q_fix = negq_q ? -dq : dq;
    assign r_fix = negr_q ? -dr : dr;

    div_iter u_div (
        .clk      (clk),
        .resetn   (resetn),
        .start    (issue && div),
        .dividend (abs_a),
        .divisor  (abs_b),
        .quotient (dq),
        .remainder(dr),
        .done     (div_done)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    if (div) begin
                        state_d = DIV;
                    end else if (mul) begin
                        state_d = MUL;
                    end else begin
                        if (HI_write && HI_MemtoReg == HILO_SRC_REG) hi_d = src_a;
                        if (LO_write && LO_MemtoReg == HILO_SRC_REG) lo_d = src_a;
                    end
                end
            end
            MUL: begin
                state_d = IDLE;
                if (hiw_q) hi_d = hilo_sel(hi_src_q, hi_q, prod_q[2*WIDTH-1:WIDTH], r_fix, a_q);
                if (low_q) lo_d = hilo_sel(lo_src_q, lo_q, prod_q[WIDTH-1:0], q_fix, a_q);
            end
            DIV: begin
                if (div_done) begin
                    state_d = IDLE;
                    if (hiw_q) hi_d = hilo_sel(hi_src_q, hi_q, prod_q[2*WIDTH-1:WIDTH], r_fix, a_q);
                    if (low_q) lo_d = hilo_sel(lo_src_q, lo_q, prod_q[WIDTH-1:0], q_fix, a_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
        if (issue) begin
            hiw_q    <= HI_write;
            low_q    <= LO_write;
            hi_src_q <= HI_MemtoReg;
            lo_src_q <= LO_MemtoReg;
            a_q      <= src_a;
            prod_q   <= prod;
            negq_q   <= div_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            negr_q   <= div_signed && src_a[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_mul_div_hilo.sv
// Self-checking bench for mul_div_hilo: directed vector table, corner-case
// sequences, and randomized operations against an arithmetic reference model.
module tb_mul_div_hilo;

    logic        clk = 1'b0;
    logic        resetn, op_valid, mul, div, mul_signed, div_signed, HI_write, LO_write;
    logic [1:0]  HI_MemtoReg, LO_MemtoReg;
    logic [31:0] src_a, src_b, hi, lo;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi, exp_lo;

    always #5 clk = ~clk;

    mul_div_hilo #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .mul(mul), .div(div),
        .mul_signed(mul_signed), .div_signed(div_signed), .HI_write(HI_write),
        .LO_write(LO_write), .HI_MemtoReg(HI_MemtoReg), .LO_MemtoReg(LO_MemtoReg),
        .src_a(src_a), .src_b(src_b), .busy(busy), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic m, d, ms, ds, hw, lw;
        logic [1:0] hs, ls;
        logic [31:0] a, b, ehi, elo;
        int ecyc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // {hi, lo} per the architectural rules, using plain integer arithmetic.
    function automatic logic [63:0] ref_result(input bit is_div, input bit sgn,
                                               input logic [31:0] a, input logic [31:0] b);
        longint pa, pb;
        logic [31:0] ma, mb, q, r;
        if (!is_div) begin
            pa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
            pb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
            return 64'(pa * pb);
        end
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        if (mb == 0) begin
            q = 32'hFFFFFFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31]) r = -r;
        return {r, q};
    endfunction

    task automatic present(input logic m, input logic d, input logic ms, input logic ds,
                           input logic hw, input logic lw, input logic [1:0] hs,
                           input logic [1:0] ls, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mul = m; div = d; mul_signed = ms; div_signed = ds;
        HI_write = hw; LO_write = lw; HI_MemtoReg = hs; LO_MemtoReg = ls;
        src_a = a; src_b = b; op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0; mul = 1'b0; div = 1'b0; HI_write = 1'b0; LO_write = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic m, input logic d, input logic ms,
                          input logic ds, input logic hw, input logic lw, input logic [1:0] hs,
                          input logic [1:0] ls, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
        int n = 0;
        bit held = 1'b1;
        present(m, d, ms, ds, hw, lw, hs, ls, a, b);
        @(negedge clk);
        while (busy && n < 100) begin
            if (hi !== exp_hi || lo !== exp_lo) held = 1'b0;
            n++;
            @(negedge clk);
        end
        chk({nm, "_busy_cycles"}, 32'(n), 32'(ecyc));
        if (ecyc > 0) chk({nm, "_held"}, {31'b0, held}, 32'd1);
        chk({nm, "_hi"}, hi, ehi);
        chk({nm, "_lo"}, lo, elo);
        exp_hi = ehi;
        exp_lo = elo;
    endtask

    initial begin
        vec_t tbl[11];
        int n;
        bit held;
        int kind;
        bit sg, hw, lw;
        logic [1:0] hs;
        logic [31:0] a, b, ehi, elo;
        logic [63:0] res;

        resetn = 1'b0; op_valid = 1'b0; mul = 1'b0; div = 1'b0; mul_signed = 1'b0;
        div_signed = 1'b0; HI_write = 1'b0; LO_write = 1'b0; HI_MemtoReg = 2'b11;
        LO_MemtoReg = 2'b11; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;

        //             m  d  ms ds hw lw hs     ls     a              b              ehi            elo            cyc
        tbl[0]  = '{1, 0, 0, 0, 1, 1, 2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1};
        tbl[1]  = '{1, 0, 1, 0, 1, 1, 2'b00, 2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1};
        tbl[2]  = '{0, 1, 0, 1, 1, 1, 2'b01, 2'b01, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 32};
        tbl[3]  = '{0, 1, 0, 0, 1, 1, 2'b01, 2'b01, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 32};
        tbl[4]  = '{0, 1, 0, 1, 1, 1, 2'b01, 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32};
        tbl[5]  = '{0, 1, 0, 1, 1, 1, 2'b01, 2'b01, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'h00000001, 32};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 2'b11, 2'b10, 32'hCAFEBABE, 32'h00000000, 32'hFFFFFFF8, 32'hCAFEBABE, 0};
        tbl[7]  = '{1, 0, 0, 0, 0, 1, 2'b11, 2'b00, 32'h00000007, 32'h00000006, 32'hFFFFFFF8, 32'h0000002A, 1};
        tbl[8]  = '{0, 1, 0, 0, 1, 1, 2'b01, 2'b01, 32'd100,      32'd7,        32'd2,        32'd14,       32};
        tbl[9]  = '{1, 1, 0, 0, 1, 1, 2'b01, 2'b01, 32'd20,       32'd6,        32'd2,        32'd3,        32};
        tbl[10] = '{0, 0, 0, 0, 1, 0, 2'b10, 2'b11, 32'h000055AA, 32'h00000000, 32'h000055AA, 32'd3,        0};

        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), tbl[i].m, tbl[i].d, tbl[i].ms, tbl[i].ds,
                   tbl[i].hw, tbl[i].lw, tbl[i].hs, tbl[i].ls, tbl[i].a, tbl[i].b,
                   tbl[i].ehi, tbl[i].elo, tbl[i].ecyc);

        // MTHI presented while a divide is in flight must be dropped.
        present(0, 1, 0, 0, 1, 1, 2'b01, 2'b01, 32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        present(0, 0, 0, 0, 1, 0, 2'b10, 2'b11, 32'h00001234, 32'd0);
        n = 0;
        held = 1'b1;
        @(negedge clk);
        while (busy && n < 100) begin
            if (hi !== exp_hi || lo !== exp_lo) held = 1'b0;
            n++;
            @(negedge clk);
        end
        chk("mthi_busy_done", {31'b0, busy}, 32'd0);
        chk("mthi_busy_held", {31'b0, held}, 32'd1);
        chk("mthi_busy_hi", hi, 32'd1);
        chk("mthi_busy_lo", lo, 32'd333);
        exp_hi = 32'd1;
        exp_lo = 32'd333;
        run_op("mthi_retry", 0, 0, 0, 0, 1, 0, 2'b10, 2'b11, 32'h00001234, 32'd0,
               32'h00001234, 32'd333, 0);

        // Reset at the tenth busy cycle of a divide.
        present(0, 1, 0, 0, 1, 1, 2'b01, 2'b01, 32'd999, 32'd4);
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        run_op("post_rst_multu", 1, 0, 0, 0, 1, 1, 2'b00, 2'b00, 32'd3, 32'd4,
               32'd0, 32'd12, 1);

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 2));
            sg   = 1'($urandom_range(0, 1));
            hw   = 1'($urandom_range(0, 1));
            lw   = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
            if (kind == 2 && !hw && !lw) lw = 1'b1;
            case (kind)
                0:       begin hs = 2'b00; res = ref_result(1'b0, sg, a, b); end
                1:       begin hs = 2'b01; res = ref_result(1'b1, sg, a, b); end
                default: begin hs = 2'b10; res = {a, a}; end
            endcase
            ehi = hw ? res[63:32] : exp_hi;
            elo = lw ? res[31:0]  : exp_lo;
            run_op($sformatf("rnd%0d", i), kind == 0, kind == 1, sg, sg, hw, lw, hs, hs,
                   a, b, ehi, elo, (kind == 0) ? 1 : (kind == 1) ? 32 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
